// File: rtl/arp_pkg.sv
// Shared constants, tx state encoding and CRC-32 byte step for the ARP transmitter.
// The FCS state only exists when ARP_TX_FCS_EN is defined.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'h06;
    localparam logic [7:0]  ARP_PLEN       = 8'h04;
    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [47:0] MAC_BROADCAST  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;

    // Terminal byte-counter values per state
    localparam logic [5:0] PREAMBLE_LAST = 6'd7;
    localparam logic [5:0] ETH_HEAD_LAST = 6'd13;
    localparam logic [5:0] ARP_DATA_LAST = 6'd27;
    localparam logic [5:0] PAD_LAST      = 6'd17;
    localparam logic [5:0] FCS_LAST      = 6'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_ETH_HEAD = 3'd2,
        ST_ARP_DATA = 3'd3,
        ST_PAD      = 3'd4,
`ifdef ARP_TX_FCS_EN
        ST_FCS      = 3'd5,
`endif
        ST_IFG      = 3'd6
    } tx_state_e;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/arp_tx_if.sv
// Start/request side and GMII transmit side of the ARP transmitter.
interface arp_tx_if;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        tx_busy;
    logic        tx_done;

    modport master (
        output arp_tx_en, arp_tx_type, des_mac, des_ip,
        input  gmii_tx_en, gmii_txd, tx_busy, tx_done
    );

    modport slave (
        input  arp_tx_en, arp_tx_type, des_mac, des_ip,
        output gmii_tx_en, gmii_txd, tx_busy, tx_done
    );
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide reflected IEEE 802.3 CRC-32 register; crc_next is the value after absorbing data.
// Only built when ARP_TX_FCS_EN is defined.
`ifdef ARP_TX_FCS_EN
module crc32_d8
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        crc_en,
    input  logic        crc_clr,
    output logic [31:0] crc_data,
    output logic [31:0] crc_next
);
    logic [31:0] crc_r;

    assign crc_data = crc_r;
    assign crc_next = crc32_byte(crc_r, data);

    // CRC accumulator: clear has priority over accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= CRC_INIT;
        end else if (crc_clr) begin
            crc_r <= CRC_INIT;
        end else if (crc_en) begin
            crc_r <= crc_next;
        end else begin
            crc_r <= crc_r;
        end
    end
endmodule
`endif

// File: rtl/arp_tx.sv
// ARP request/reply frame transmitter onto GMII. Define ARP_TX_FCS_EN to append the
// CRC-32 FCS (72-cycle frame); otherwise the frame ends after the pad (68 cycles).
module arp_tx
    import arp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic     clk,
    input  logic     rst,
    arp_tx_if.slave  tx_if
);
    localparam logic [5:0] IFG_LAST = 6'(IFG_CYCLES - 1);

    tx_state_e    state_r, state_nxt_s;
    logic [5:0]   cnt_r, cnt_nxt_s;
    logic         type_r;
    logic [47:0]  des_mac_r;
    logic [31:0]  des_ip_r;
    logic [7:0]   txd_r, byte_s;
    logic         tx_en_r, tx_en_s, busy_r, done_r, done_s, accept_s;
    logic [111:0] eth_vec_s, eth_sh_s;
    logic [223:0] arp_vec_s, arp_sh_s;

    assign accept_s = (state_r == ST_IDLE) && tx_if.arp_tx_en;

    // Next state and byte counter; counter restarts on every state change
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + 6'd1;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s   = 6'd0;
                state_nxt_s = tx_if.arp_tx_en ? ST_PREAMBLE : ST_IDLE;
            end
            ST_PREAMBLE: if (cnt_r == PREAMBLE_LAST) begin
                state_nxt_s = ST_ETH_HEAD; cnt_nxt_s = 6'd0;
            end else begin
                state_nxt_s = ST_PREAMBLE;
            end
            ST_ETH_HEAD: if (cnt_r == ETH_HEAD_LAST) begin
                state_nxt_s = ST_ARP_DATA; cnt_nxt_s = 6'd0;
            end else begin
                state_nxt_s = ST_ETH_HEAD;
            end
            ST_ARP_DATA: if (cnt_r == ARP_DATA_LAST) begin
                state_nxt_s = ST_PAD; cnt_nxt_s = 6'd0;
            end else begin
                state_nxt_s = ST_ARP_DATA;
            end
`ifdef ARP_TX_FCS_EN
            ST_PAD: if (cnt_r == PAD_LAST) begin
                state_nxt_s = ST_FCS; cnt_nxt_s = 6'd0;
            end else begin
                state_nxt_s = ST_PAD;
            end
            ST_FCS: if (cnt_r == FCS_LAST) begin
                state_nxt_s = ST_IFG; cnt_nxt_s = 6'd0;
            end else begin
                state_nxt_s = ST_FCS;
            end
`else
            ST_PAD: if (cnt_r == PAD_LAST) begin
                state_nxt_s = ST_IFG; cnt_nxt_s = 6'd0;
            end else begin
                state_nxt_s = ST_PAD;
            end
`endif
            ST_IFG: if (cnt_r == IFG_LAST) begin
                state_nxt_s = ST_IDLE; cnt_nxt_s = 6'd0;
            end else begin
                state_nxt_s = ST_IFG;
            end
            default: begin
                state_nxt_s = ST_IDLE; cnt_nxt_s = 6'd0;
            end
        endcase
    end

`ifdef ARP_TX_FCS_EN
    logic [31:0] crc_data_s, crc_next_s, fcs_word_s, fcs_sh_s;
    logic        crc_en_s, crc_clr_s;

    // CRC follows the byte currently on the wire (txd_r), so when entering FCS the
    // last pad byte is only in crc_next; afterwards the register holds the final value.
    assign crc_en_s   = (state_r == ST_ETH_HEAD) || (state_r == ST_ARP_DATA) || (state_r == ST_PAD);
    assign crc_clr_s  = (state_r == ST_IDLE);
    assign fcs_word_s = (state_r == ST_FCS) ? crc_data_s : crc_next_s;
    assign fcs_sh_s   = (~fcs_word_s) >> {cnt_nxt_s[1:0], 3'b000};

    crc32_d8 u_crc (
        .clk      (clk),
        .rst      (rst),
        .data     (txd_r),
        .crc_en   (crc_en_s),
        .crc_clr  (crc_clr_s),
        .crc_data (crc_data_s),
        .crc_next (crc_next_s)
    );
`endif

    // Byte for the state/count being entered, so the output register lines up with it
    always_comb begin
        eth_vec_s = {(type_r ? des_mac_r : MAC_BROADCAST), BOARD_MAC, ETH_TYPE_ARP};
        arp_vec_s = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
                     (type_r ? ARP_OP_REPLY : ARP_OP_REQUEST), BOARD_MAC, BOARD_IP,
                     (type_r ? des_mac_r : 48'h0000_0000_0000), des_ip_r};
        eth_sh_s  = eth_vec_s << {cnt_nxt_s, 3'b000};
        arp_sh_s  = arp_vec_s << {cnt_nxt_s, 3'b000};
        byte_s    = 8'h00;
        case (state_nxt_s)
            ST_PREAMBLE: byte_s = (cnt_nxt_s == PREAMBLE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            ST_ETH_HEAD: byte_s = eth_sh_s[111:104];
            ST_ARP_DATA: byte_s = arp_sh_s[223:216];
`ifdef ARP_TX_FCS_EN
            ST_FCS:      byte_s = fcs_sh_s[7:0];
`endif
            default:     byte_s = 8'h00;
        endcase
        tx_en_s = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_IFG);
        done_s  = (state_nxt_s == ST_IFG) && (state_r != ST_IFG);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
            txd_r   <= 8'h00;
            tx_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            txd_r   <= tx_en_s ? byte_s : 8'h00;
            tx_en_r <= tx_en_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= done_s;
        end
    end

    // Request fields captured only when a start is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_r    <= 1'b0;
            des_mac_r <= 48'h0000_0000_0000;
            des_ip_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            type_r    <= tx_if.arp_tx_type;
            des_mac_r <= tx_if.des_mac;
            des_ip_r  <= tx_if.des_ip;
        end else begin
            type_r    <= type_r;
            des_mac_r <= des_mac_r;
            des_ip_r  <= des_ip_r;
        end
    end

    assign tx_if.gmii_tx_en = tx_en_r;
    assign tx_if.gmii_txd   = txd_r;
    assign tx_if.tx_busy    = busy_r;
    assign tx_if.tx_done    = done_r;
endmodule

// File: tb/tb_arp_tx.sv
// Randomised self-checking bench for arp_tx: expected frames are assembled byte by byte
// from the ARP/Ethernet field layout, with a bit-serial CRC-32 for the FCS.
module tb_arp_tx;
    localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IP  = 32'hC0A8_010A;
    localparam int IFG = 12;
`ifdef ARP_TX_FCS_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif
    localparam int FRAME_LEN = 8 + 14 + 28 + 18 + FCS_LEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arp_tx_if dut_if ();
    arp_tx #(.BOARD_MAC(MAC), .BOARD_IP(IP), .IFG_CYCLES(IFG)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (dut_if)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int done_cnt = 0, rise_cnt = 0, busy_cycles = 0, idle_bad = 0;
    logic en_prev = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Passive wire monitor
    always @(negedge clk) begin
        if (dut_if.gmii_tx_en === 1'b1) begin
            cap_q.push_back(dut_if.gmii_txd);
            if (!en_prev) rise_cnt++;
        end else if (dut_if.gmii_txd !== 8'h00) begin
            idle_bad++;
        end
        en_prev = (dut_if.gmii_tx_en === 1'b1);
        if (dut_if.tx_done === 1'b1) done_cnt++;
        if (dut_if.tx_busy === 1'b1) busy_cycles++;
    end

    function automatic logic [31:0] crc_over(input logic [7:0] q[$], input int from);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic fb;
        for (int i = from; i < q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    function automatic logic [63:0] get_be(input logic [7:0] q[$], input int idx, input int n);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = {v[55:0], (idx + i < q.size()) ? q[idx + i] : 8'h00};
        return v;
    endfunction

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build_frame(input logic typ, input logic [47:0] m, input logic [31:0] ip);
        logic [31:0] fcs;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be(typ ? {16'd0, m} : 64'hFFFF_FFFF_FFFF, 6);
        push_be({16'd0, MAC}, 6);
        push_be(64'h0806, 2);
        push_be(64'h0001, 2);
        push_be(64'h0800, 2);
        push_be(64'h06, 1);
        push_be(64'h04, 1);
        push_be(typ ? 64'h2 : 64'h1, 2);
        push_be({16'd0, MAC}, 6);
        push_be({32'd0, IP}, 4);
        push_be(typ ? {16'd0, m} : 64'd0, 6);
        push_be({32'd0, ip}, 4);
        repeat (18) exp_q.push_back(8'h00);
        if (FCS_LEN == 4) begin
            fcs = ~crc_over(exp_q, 8);
            for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
        end
    endtask

    task automatic compare_frame(input string tag);
        int bad = 0;
        logic [31:0] res;
        check_val({tag, "_len"}, 64'(cap_q.size()), 64'(FRAME_LEN));
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) bad++;
        end
        check_val({tag, "_bad_bytes"}, 64'(bad), 64'd0);
`ifdef ARP_TX_FCS_EN
        res = crc_over(cap_q, 8);
        res = {<<{res}};
        check_val({tag, "_crc_residue"}, {32'd0, res}, 64'hC704_DD7B);
`else
        res = 32'd0;
        for (int i = FRAME_LEN - 18; i < cap_q.size(); i++) res = res | {24'd0, cap_q[i]};
        check_val({tag, "_pad_tail"}, {32'd0, res}, 64'd0);
`endif
    endtask

    // Drives a start in cycle 0 and returns in cycle 1 with the start removed
    task automatic start_frame(input logic typ, input logic [47:0] m, input logic [31:0] ip);
        @(negedge clk);
        cap_q.delete();
        busy_cycles = 0;
        dut_if.arp_tx_en   = 1'b1;
        dut_if.arp_tx_type = typ;
        dut_if.des_mac     = m;
        dut_if.des_ip      = ip;
        build_frame(typ, m, ip);
        @(negedge clk);
        dut_if.arp_tx_en   = 1'b0;
        dut_if.arp_tx_type = ~typ;
        dut_if.des_mac     = {16'($urandom()), $urandom()};
        dut_if.des_ip      = $urandom();
        check_val("latency_en", {63'd0, dut_if.gmii_tx_en}, 64'd1);
        check_val("latency_txd", {56'd0, dut_if.gmii_txd}, 64'h55);
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", {63'd0, done_cnt != d0}, 64'd1);
        repeat (IFG + 3) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic typ, input logic [47:0] m,
                             input logic [31:0] ip);
        int d0 = done_cnt;
        int r0 = rise_cnt;
        start_frame(typ, m, ip);
        wait_done(d0);
        compare_frame(tag);
        check_val({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check_val({tag, "_one_burst"}, 64'(rise_cnt - r0), 64'd1);
        check_val({tag, "_busy_len"}, 64'(busy_cycles), 64'(FRAME_LEN + IFG));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;
        logic [47:0] m;
        logic [31:0] ip;
        dut_if.arp_tx_en   = 1'b0;
        dut_if.arp_tx_type = 1'b0;
        dut_if.des_mac     = 48'd0;
        dut_if.des_ip      = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_tx_en", {63'd0, dut_if.gmii_tx_en}, 64'd0);
        check_val("rst_txd", {56'd0, dut_if.gmii_txd}, 64'd0);
        check_val("rst_busy", {63'd0, dut_if.tx_busy}, 64'd0);
        check_val("rst_done", {63'd0, dut_if.tx_done}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("reply", 1'b1, 48'hAA_BB_CC_DD_EE_FF, 32'hC0A8_0166);
        check_val("reply_dst", get_be(cap_q, 8, 6), 64'hAABB_CCDD_EEFF);
        check_val("reply_opcode", get_be(cap_q, 28, 2), 64'h0002);
        check_val("reply_tip", get_be(cap_q, 46, 4), 64'hC0A8_0166);

        run_frame("request", 1'b0, 48'h1234_5678_9ABC, 32'hC0A8_0105);
        check_val("req_dst", get_be(cap_q, 8, 6), 64'hFFFF_FFFF_FFFF);
        check_val("req_tmac", get_be(cap_q, 40, 6), 64'h0);
        check_val("req_opcode", get_be(cap_q, 28, 2), 64'h0001);

        for (int k = 0; k < 5; k++) begin
            m  = {16'($urandom()), $urandom()};
            ip = $urandom();
            run_frame("random", 1'($urandom_range(1, 0)), m, ip);
        end

        // Starts mid-frame and on the last IFG cycle must be ignored
        d0 = done_cnt;
        r0 = rise_cnt;
        m  = {16'($urandom()), $urandom()};
        start_frame(1'b1, m, 32'hC0A8_0177);
        for (int c = 2; c <= FRAME_LEN + IFG + 20; c++) begin
            @(negedge clk);
            dut_if.arp_tx_en = (c == 20 || c == FRAME_LEN + IFG);
            dut_if.des_mac   = {16'($urandom()), $urandom()};
        end
        dut_if.arp_tx_en = 1'b0;
        compare_frame("ignore");
        check_val("ignore_done_once", 64'(done_cnt - d0), 64'd1);
        check_val("ignore_one_burst", 64'(rise_cnt - r0), 64'd1);
        check_val("ignore_busy_len", 64'(busy_cycles), 64'(FRAME_LEN + IFG));

        // Reset in cycle 30 truncates the frame
        d0 = done_cnt;
        start_frame(1'b0, 48'd0, 32'hC0A8_0199);
        for (int c = 2; c <= 30; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_tx_en", {63'd0, dut_if.gmii_tx_en}, 64'd0);
        check_val("midrst_txd", {56'd0, dut_if.gmii_txd}, 64'd0);
        check_val("midrst_busy", {63'd0, dut_if.tx_busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        r0 = rise_cnt;
        repeat (100) @(negedge clk);
        check_val("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("midrst_no_bytes", 64'(rise_cnt - r0), 64'd0);
        run_frame("after_rst", 1'b1, 48'hAA_BB_CC_DD_EE_FF, 32'hC0A8_0166);

        check_val("idle_txd_zero", 64'(idle_bad), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
